// File: rtl/ps2_key_event_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_filter
// Brief    : Set-2 PS/2 byte stream to press/release/held key events with
//            E0/F0 prefix decoding, typematic suppression and prefix timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_filter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_held,
  output logic       key_press,
  output logic       key_release,
  output logic       err
);

  localparam logic [7:0] c_BYTE_EXT = 8'hE0;
  localparam logic [7:0] c_BYTE_BRK = 8'hF0;
  // Expiry fires in the cycle whose increment would bring the count to
  // TIMEOUT_CYCLES-1, so the err pulse is visible TIMEOUT_CYCLES cycles
  // after the prefix strobe.
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_is_ext;
  logic             w_is_brk;
  logic             w_make;
  logic             w_break;
  logic             w_ext_flag;
  logic             w_err;
  logic             w_expire;
  logic             w_match;

  assign w_is_ext = (ps2_key_data == c_BYTE_EXT);
  assign w_is_brk = (ps2_key_data == c_BYTE_BRK);
  assign w_expire = (r_state != S_IDLE) && !ps2_key_pressed && (r_cnt == c_LAST);
  assign w_match  = key_held && (ps2_key_data == key_code) && (w_ext_flag == key_ext);

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_ext_flag  = 1'b0;
    w_err       = 1'b0;
    if (ps2_key_pressed) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_brk)                                       w_state_nxt = S_BRK;
          else if (w_is_ext)                                  w_state_nxt = S_EXT;
          else if (ps2_key_data == 8'h00 || ps2_key_data == 8'hFF) w_err = 1'b1;
          else                                                w_make      = 1'b1;
        end
        S_EXT: begin
          w_ext_flag = 1'b1;
          if (w_is_brk)      w_state_nxt = S_EXT_BRK;
          else if (w_is_ext) w_err       = 1'b1;
          else begin
            w_make      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          // Both break states: a prefix byte here is a protocol error.
          w_ext_flag  = (r_state == S_EXT_BRK);
          w_state_nxt = S_IDLE;
          if (w_is_brk || w_is_ext) w_err   = 1'b1;
          else                      w_break = 1'b1;
        end
      endcase
    end else if (w_expire) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_held    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      err         <= w_err;
      if (ps2_key_pressed || r_state == S_IDLE || w_expire) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + 1'b1;
      if (w_make && !w_match) begin
        key_code  <= ps2_key_data;
        key_ext   <= w_ext_flag;
        key_held  <= 1'b1;
        key_press <= 1'b1;
      end
      if (w_break && w_match) begin
        key_held    <= 1'b0;
        key_release <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
